// File: rtl/iis_sample_feeder.sv
// Stereo sample FIFO feeding the IIS serial writer: accepts 24-bit L/R pairs,
// presents one pair per lrclk frame, advancing on each left-channel start edge.
module iis_sample_feeder #(
   parameter int DEPTH  = 16,
   parameter int AW     = 4,
   parameter int UCNT_W = 16
) (
   input  logic              clk_100m,
   input  logic              rst_n,
   input  logic              en,
   input  logic              lrclk,
   input  logic              s_valid,
   input  logic [23:0]       s_ldata,
   input  logic [23:0]       s_rdata,
   output logic              s_ready,
   output logic [23:0]       ldata,
   output logic [23:0]       rdata,
   output logic [AW:0]       level,
   output logic              empty,
   output logic              full,
   output logic              underrun,
   output logic [UCNT_W-1:0] underrun_cnt
);

   localparam logic [AW:0]       LVL_ONE  = (AW+1)'(1);
   localparam logic [AW:0]       LVL_FULL = (AW+1)'(DEPTH);
   localparam logic [AW-1:0]     PTR_ONE  = AW'(1);
   localparam logic [UCNT_W-1:0] CNT_ONE  = UCNT_W'(1);

   logic [47:0]       r_mem [DEPTH];
   logic [AW-1:0]     r_wptr;
   logic [AW-1:0]     r_rptr;
   logic [AW:0]       r_level;
   logic              r_lrclk_d1;
   logic [23:0]       r_ldata;
   logic [23:0]       r_rdata;
   logic              r_underrun;
   logic [UCNT_W-1:0] r_ucnt;

   logic              w_left_edge;
   logic              w_empty;
   logic              w_full;
   logic              w_ready;
   logic              w_push;
   logic              w_pop;
   logic              w_frame_start;
   logic [AW:0]       w_level_nxt;

   // Single-register edge detect keeps us cycle-aligned with the writer.
   assign w_left_edge   = r_lrclk_d1 & ~lrclk;
   assign w_empty       = (r_level == {(AW+1){1'b0}});
   assign w_full        = (r_level == LVL_FULL);
   assign w_ready       = en & ~w_full;
   assign w_push        = s_valid & w_ready;
   assign w_frame_start = w_left_edge & en;
   assign w_pop         = w_frame_start & ~w_empty;

   // Next fill level from this cycle's push/pop pair.
   always_comb begin
      w_level_nxt = r_level;
      if (w_push && !w_pop) begin
         w_level_nxt = r_level + LVL_ONE;
      end else if (w_pop && !w_push) begin
         w_level_nxt = r_level - LVL_ONE;
      end else begin
         w_level_nxt = r_level;
      end
   end

   // Sample storage; contents are only read at positions covered by level.
   always_ff @(posedge clk_100m) begin
      if (w_push) begin
         r_mem[r_wptr] <= {s_ldata, s_rdata};
      end
   end

   // Pointers, level and lrclk history; en low flushes the FIFO.
   always_ff @(posedge clk_100m or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr     <= {AW{1'b0}};
         r_rptr     <= {AW{1'b0}};
         r_level    <= {(AW+1){1'b0}};
         r_lrclk_d1 <= 1'b0;
      end else begin
         r_lrclk_d1 <= lrclk;
         if (!en) begin
            r_wptr  <= {AW{1'b0}};
            r_rptr  <= {AW{1'b0}};
            r_level <= {(AW+1){1'b0}};
         end else begin
            if (w_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
            r_level <= w_level_nxt;
         end
      end
   end

   // Presented pair and underrun bookkeeping, touched only at frame start.
   always_ff @(posedge clk_100m or negedge rst_n) begin
      if (!rst_n) begin
         r_ldata    <= 24'd0;
         r_rdata    <= 24'd0;
         r_underrun <= 1'b0;
         r_ucnt     <= {UCNT_W{1'b0}};
      end else if (!en) begin
         r_ldata <= 24'd0;
         r_rdata <= 24'd0;
      end else if (w_frame_start) begin
         if (w_empty) begin
            r_ldata    <= 24'd0;
            r_rdata    <= 24'd0;
            r_underrun <= 1'b1;
            if (r_ucnt != {UCNT_W{1'b1}}) r_ucnt <= r_ucnt + CNT_ONE;
         end else begin
            r_ldata <= r_mem[r_rptr][47:24];
            r_rdata <= r_mem[r_rptr][23:0];
         end
      end
   end

   assign s_ready      = w_ready;
   assign ldata        = r_ldata;
   assign rdata        = r_rdata;
   assign level        = r_level;
   assign empty        = w_empty;
   assign full         = w_full;
   assign underrun     = r_underrun;
   assign underrun_cnt = r_ucnt;

endmodule

// File: tb/tb_iis_sample_feeder.sv
// Self-checking bench for iis_sample_feeder: directed plan steps plus random
// traffic compared against a queue-based frame model.
module tb_iis_sample_feeder;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        en = 1'b0;
   logic        lrclk = 1'b0;
   logic        s_valid = 1'b0;
   logic [23:0] s_ldata = 24'd0;
   logic [23:0] s_rdata = 24'd0;

   logic        s_ready, empty, full, underrun;
   logic [23:0] ldata, rdata;
   logic [AW:0] level;
   logic [15:0] underrun_cnt;

   logic        s_ready2, empty2, full2, underrun2;
   logic [23:0] ldata2, rdata2;
   logic [AW:0] level2;
   logic [1:0]  underrun_cnt2;

   iis_sample_feeder #(.DEPTH(DEPTH), .AW(AW), .UCNT_W(16)) dut (
      .clk_100m(clk), .rst_n(rst_n), .en(en), .lrclk(lrclk), .s_valid(s_valid),
      .s_ldata(s_ldata), .s_rdata(s_rdata), .s_ready(s_ready), .ldata(ldata),
      .rdata(rdata), .level(level), .empty(empty), .full(full),
      .underrun(underrun), .underrun_cnt(underrun_cnt));

   iis_sample_feeder #(.DEPTH(DEPTH), .AW(AW), .UCNT_W(2)) dut2 (
      .clk_100m(clk), .rst_n(rst_n), .en(en), .lrclk(lrclk), .s_valid(s_valid),
      .s_ldata(s_ldata), .s_rdata(s_rdata), .s_ready(s_ready2), .ldata(ldata2),
      .rdata(rdata2), .level(level2), .empty(empty2), .full(full2),
      .underrun(underrun2), .underrun_cnt(underrun_cnt2));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: a queue of pairs plus the pair currently presented.
   logic [47:0] q[$];
   logic [23:0] m_l, m_r;
   logic        m_und;
   int          m_cnt;
   logic        m_lrprev;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_l = 24'd0; m_r = 24'd0; m_und = 1'b0; m_cnt = 0; m_lrprev = 1'b0;
   endtask

   task automatic check_outs(input string ph);
      int c2;
      c2 = (m_cnt > 3) ? 3 : m_cnt;
      chk({ph, ".ldata"}, 64'(ldata), 64'(m_l));
      chk({ph, ".rdata"}, 64'(rdata), 64'(m_r));
      chk({ph, ".level"}, 64'(level), 64'(q.size()));
      chk({ph, ".empty"}, 64'(empty), 64'(q.size() == 0));
      chk({ph, ".full"}, 64'(full), 64'(q.size() == DEPTH));
      chk({ph, ".underrun"}, 64'(underrun), 64'(m_und));
      chk({ph, ".ucnt"}, 64'(underrun_cnt), 64'(m_cnt));
      chk({ph, ".ucnt2"}, 64'(underrun_cnt2), 64'(c2));
   endtask

   // One clock: apply inputs, check s_ready, advance model, check outputs after the edge.
   task automatic cycle(input string ph, input bit e, input bit lr, input bit v,
                        input logic [23:0] l, input logic [23:0] r);
      bit ready;
      en = e; lrclk = lr; s_valid = v; s_ldata = l; s_rdata = r;
      #1;
      ready = e && (q.size() < DEPTH);
      chk({ph, ".s_ready"}, 64'(s_ready), 64'(ready));
      if (!e) begin
         q.delete(); m_l = 24'd0; m_r = 24'd0;
      end else begin
         if (m_lrprev && !lr) begin
            if (q.size() > 0) begin
               {m_l, m_r} = q.pop_front();
            end else begin
               m_l = 24'd0; m_r = 24'd0; m_und = 1'b1;
               if (m_cnt < 65535) m_cnt++;
            end
         end
         if (v && ready) q.push_back({l, r});
      end
      m_lrprev = lr;
      @(posedge clk); #1;
      check_outs(ph);
   endtask

   task automatic do_reset(input string ph);
      en = 1'b0; lrclk = 1'b0; s_valid = 1'b0; s_ldata = 24'd0; s_rdata = 24'd0;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outs(ph);
      chk({ph, ".s_ready"}, 64'(s_ready), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [23:0] rl, rr;
      bit          v, e, lr;
      int          ctr;

      model_reset();
      #2;
      do_reset("reset");

      // Three pairs, then three frames.
      for (int i = 1; i <= 3; i++)
         cycle("t1.push", 1'b1, 1'b1, 1'b1, 24'(i), 24'h800000 | 24'(i));
      cycle("t1.idle", 1'b1, 1'b1, 1'b0, 24'd0, 24'd0);
      chk("t1.level3", 64'(level), 64'd3);
      for (int i = 1; i <= 3; i++) begin
         cycle("t1.edge", 1'b1, 1'b0, 1'b0, 24'd0, 24'd0);
         chk("t1.ldata", 64'(ldata), 64'(i));
         chk("t1.rdata", 64'(rdata), 64'(24'h800000 | 24'(i)));
         cycle("t1.high", 1'b1, 1'b1, 1'b0, 24'd0, 24'd0);
      end
      chk("t1.no_underrun", 64'(underrun), 64'd0);

      // Fill to DEPTH, 17th rejected, one pop frees space a cycle later.
      do_reset("t2.reset");
      for (int i = 0; i < DEPTH; i++)
         cycle("t2.push", 1'b1, 1'b1, 1'b1, 24'(i + 16), 24'(i + 32));
      chk("t2.full", 64'(full), 64'd1);
      chk("t2.level16", 64'(level), 64'd16);
      cycle("t2.push17", 1'b1, 1'b1, 1'b1, 24'h00ABCD, 24'h00DCBA);
      chk("t2.level_hold", 64'(level), 64'd16);
      cycle("t2.edge", 1'b1, 1'b0, 1'b1, 24'h00ABCD, 24'h00DCBA);
      chk("t2.level15", 64'(level), 64'd15);
      chk("t2.ready_next", 64'(s_ready), 64'd1);
      chk("t2.ldata", 64'(ldata), 64'd16);

      // Five frames on an empty FIFO; 2-bit counter saturates at 3.
      do_reset("t3.reset");
      for (int i = 0; i < 5; i++) begin
         cycle("t3.high", 1'b1, 1'b1, 1'b0, 24'd0, 24'd0);
         cycle("t3.edge", 1'b1, 1'b0, 1'b0, 24'd0, 24'd0);
      end
      chk("t3.ucnt5", 64'(underrun_cnt), 64'd5);
      chk("t3.ucnt_sat", 64'(underrun_cnt2), 64'd3);
      chk("t3.underrun", 64'(underrun), 64'd1);

      // Push coinciding with an edge at level 4 and at level 0.
      do_reset("t4.reset");
      for (int i = 0; i < 4; i++)
         cycle("t4.push", 1'b1, 1'b1, 1'b1, 24'h100 + 24'(i), 24'h200 + 24'(i));
      cycle("t4.both", 1'b1, 1'b0, 1'b1, 24'h0000EE, 24'h0000FF);
      chk("t4.level4", 64'(level), 64'd4);
      chk("t4.ldata", 64'(ldata), 64'h100);
      do_reset("t4.reset0");
      cycle("t4.high0", 1'b1, 1'b1, 1'b0, 24'd0, 24'd0);
      cycle("t4.both0", 1'b1, 1'b0, 1'b1, 24'hAAAAAA, 24'hBBBBBB);
      chk("t4.ucnt1", 64'(underrun_cnt), 64'd1);
      chk("t4.silence", 64'(ldata), 64'd0);
      cycle("t4.high1", 1'b1, 1'b1, 1'b0, 24'd0, 24'd0);
      cycle("t4.edge1", 1'b1, 1'b0, 1'b0, 24'd0, 24'd0);
      chk("t4.late_pair", 64'(ldata), 64'hAAAAAA);

      // Flush at level 7, then re-enable with one pair.
      do_reset("t5.reset");
      cycle("t5.high", 1'b1, 1'b1, 1'b0, 24'd0, 24'd0);
      cycle("t5.edge", 1'b1, 1'b0, 1'b0, 24'd0, 24'd0);
      for (int i = 0; i < 7; i++)
         cycle("t5.push", 1'b1, 1'b1, 1'b1, 24'h300 + 24'(i), 24'h400 + 24'(i));
      cycle("t5.flush", 1'b0, 1'b1, 1'b0, 24'd0, 24'd0);
      chk("t5.level0", 64'(level), 64'd0);
      chk("t5.ucnt_hold", 64'(underrun_cnt), 64'd1);
      chk("t5.ready0", 64'(s_ready), 64'd0);
      cycle("t5.push1", 1'b1, 1'b1, 1'b1, 24'h123456, 24'h654321);
      cycle("t5.low", 1'b1, 1'b0, 1'b0, 24'd0, 24'd0);
      chk("t5.ldata", 64'(ldata), 64'h123456);
      chk("t5.rdata", 64'(rdata), 64'h654321);

      // Asynchronous reset in the middle of a clock period.
      cycle("t6.push", 1'b1, 1'b1, 1'b1, 24'h777777, 24'h888888);
      do_reset("t6.async");

      // Random traffic with a 5-cycle lrclk half period and occasional flushes.
      ctr = 0; v = 1'b0; rl = 24'd0; rr = 24'd0;
      for (int n = 0; n < 4000; n++) begin
         if (!(v && !s_ready)) begin
            v  = ($urandom_range(0, 99) < 55);
            rl = 24'($urandom);
            rr = 24'($urandom);
         end
         e  = ($urandom_range(0, 199) != 0);
         lr = ((ctr / 5) % 2) == 1;
         ctr++;
         cycle("rand", e, lr, v, rl, rr);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/iis_sample_feeder.md
Name: iis_sample_feeder

Overview:
- Stereo sample buffer sitting directly upstream of the IIS serial writer.
- Accepts 24-bit left/right pairs from the audio source over a valid/ready handshake and stores them in a FIFO.
- Presents one pair on ldata/rdata, held stable for a whole lrclk frame. It advances to the next pair on each lrclk falling edge (left-channel start), the same edge on which the writer latches its data.
- Underflow inserts silence and is counted.

Parameters:
DEPTH, 16, FIFO depth in stereo pairs; power of two, 2 to 256.
AW, 4, address width; equals log2(DEPTH).
UCNT_W, 16, width of the underrun counter.

Ports:
clk_100m  input  1  system clock.
rst_n  input  1  asynchronous active-low reset.
en  input  1  enable; shared with the serial writer.
lrclk  input  1  frame clock (low = left); synchronous to clk_100m.
s_valid  input  1  source pair valid.
s_ldata  input  24  source left sample.
s_rdata  input  24  source right sample.
s_ready  output  1  feeder can accept a pair.
ldata  output  24  current left sample to the writer.
rdata  output  24  current right sample to the writer.
level  output  AW+1  number of pairs stored in the FIFO (0..DEPTH).
empty  output  1  level == 0.
full  output  1  level == DEPTH.
underrun  output  1  sticky: a frame edge found the FIFO empty.
underrun_cnt  output  UCNT_W  count of underrun frames; saturates at all-ones.

Behaviour:
- Reset values:
  - s_ready=0, ldata=0, rdata=0, level=0, empty=1, full=0, underrun=0, underrun_cnt=0.
  - Read pointer, write pointer and lrclk_d1 all cleared.
- Clocking: one clock domain, clk_100m, with asynchronous active-low reset rst_n. All outputs are registered except s_ready, empty and full, which are decoded from registers.
- Edge detect:
  - lrclk_d1 is lrclk registered once.
  - left_edge = lrclk_d1 & !lrclk, combinational.
  - This must match the writer's own left-start detection cycle-for-cycle. No extra synchroniser stages are allowed.
- FIFO:
  - Storage is DEPTH x 48 bits, holding {ldata,rdata}. Write and read pointers are AW bits and wrap modulo DEPTH.
  - s_ready = en & !full.
  - Push occurs when s_valid & s_ready. The pair is written at the write pointer, and the pointer increments.
  - Pop occurs when left_edge & en & !empty.
- Output update at left_edge (en=1):
  - FIFO non-empty: ldata/rdata <= head pair on the next clock; the read pointer increments.
  - FIFO empty: ldata/rdata <= 0; underrun <= 1; underrun_cnt increments, saturating.
- Timing: ldata/rdata never change except in the clock after a left_edge. The writer therefore samples, in the left_edge cycle, the pair loaded at the previous left_edge. Latency is exactly one frame from pop to serialisation.
- Simultaneous push and pop: both occur in the same cycle and level is unchanged. A push into an empty FIFO in the left_edge cycle does NOT satisfy that edge: it counts as an underrun, and the pair is used at the next edge.
- Full: s_ready=0 and the source must hold its data. A pop in that cycle does not raise s_ready until the next cycle.
- level = number of pushes minus number of pops. It is updated every clock, and empty/full are derived from it.
- en low, sampled every clock:
  - Both pointers and level are cleared (flush); ldata=rdata=0; s_ready=0.
  - underrun and underrun_cnt hold their values; only rst_n clears them.
  - No pop and no underrun counting occurs.
- Re-enable: the first left_edge after en rises pops the head if it is present, otherwise it is an underrun.
- Reset mid-operation clears everything immediately and asynchronously. Stored data is discarded.

Test Plan:
- Reset, then en=1 with 3 pairs pushed (L=0x000001/R=0x800001, L=0x000002/R=0x800002, L=0x000003/R=0x800003) and an lrclk period of 64 bclk -> level=3. ldata/rdata are 0x000001/0x800001 after the 1st left_edge, 0x000002/0x800002 after the 2nd, 0x000003/0x800003 after the 3rd. No underrun.
- Push DEPTH=16 pairs with no lrclk edges -> full=1, s_ready=0, level=16. A 17th s_valid is not accepted. After one left_edge, level=15 and s_ready=1 on the following cycle.
- Empty FIFO, 5 left_edges -> ldata=rdata=0, underrun=1, underrun_cnt=5. With UCNT_W=2 and 5 edges, underrun_cnt=3 (saturated).
- Push and left_edge in the same cycle at level=4 -> level stays 4 and the correct pair is presented. The same event at level=0 -> underrun_cnt increments and the pushed pair appears at the next edge.
- en driven low at level=7 mid-frame -> next cycle level=0, ldata=rdata=0, s_ready=0, underrun_cnt unchanged. en back high with 1 pair pushed -> that pair is presented after the next left_edge.
- Chained with the serial writer (lrclk/bclk from the clock generator) -> the writer's sdata reproduces each pushed pair MSB-first in order, with zero frames exactly where underrun_cnt increments.
